interconn_txq: RTL and testbench
================================

Name: interconn_txq

Overview:
Per-MVU outbound transmit queue, directly upstream of the MVU interconnect crossbar. It accepts write requests from the local MVU over a valid/ready handshake. Each request is a destination mask, a remote memory address and a data word. Requests are buffered in a DEPTH-entry circular FIFO and issued to the crossbar source port at most one per cycle, through registered outputs. Issue is gated by a global hold input, so the system can stall all sources while the crossbar is reconfigured or a destination is busy.

Parameters:
N, 8, number of MVUs; width of destination mask
W, 64, data word width
BADDR, 15, remote memory address width
DEPTH, 4, FIFO entries; power of two, >= 2
AW, 2, log2(DEPTH)

Ports:
clk  input  1  clock, rising edge
clr  input  1  asynchronous active-high reset
in_valid  input  1  producer request valid
in_ready  output  1  queue can accept a request
in_to  input  N  destination MVU mask (bit j = send to MVU j)
in_addr  input  BADDR  remote write address
in_word  input  W  data word
hold  input  1  suppress issue this cycle
flush  input  1  discard all queued entries
send_to  output  N  to crossbar: destination mask
send_en  output  1  to crossbar: issue strobe
send_addr  output  BADDR  to crossbar: address
send_word  output  W  to crossbar: data
count  output  AW+1  entries currently queued
drop_err  output  1  sticky: zero-mask request received

Behaviour:
- Reset (clr high, asynchronous): rd/wr pointers 0, count 0, send_en 0, send_to/send_addr/send_word 0, drop_err 0. in_ready is 0 while clr is high.
- Pointers are AW+1 bits with a wrap bit. Empty when the pointers are equal. Full when the low bits are equal and the wrap bits differ. count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- in_ready = !full & !flush. The flag is combinational from registered state only. It does not look ahead to a same-cycle pop.
- Push: in_valid & in_ready at an edge writes {in_to, in_addr, in_word} at wr_ptr and increments wr_ptr.
- Zero-mask request (in_to == 0): it is accepted (handshake completes), not stored, and sets drop_err. drop_err clears only on clr.
- Pop: at an edge where !empty & !hold & !flush:
  - the entry at rd_ptr is loaded into the send_* registers, send_en is set to 1, and rd_ptr increments.
  - Otherwise send_en is set to 0 and send_to/send_addr/send_word are set to 0. This keeps the crossbar OR-reduction clean.
- send_en is high for exactly one cycle per entry. Back-to-back entries produce consecutive send_en cycles with no bubble.
- Latency: a push at edge E0 into an empty queue with hold low gives send_en high after edge E0+1 (one cycle in the FIFO). The crossbar adds its own register stage after that.
- Simultaneous push and pop in the same edge are both performed; count is unchanged. When full, a pop frees a slot, and in_ready rises the following cycle.
- hold affects issue only; pushes continue until full. After hold deasserts, issue resumes at the next edge in FIFO order.
- flush: at any edge where flush is high, rd_ptr is set to wr_ptr, count becomes 0, any push in that cycle is ignored (in_ready is low), and send_en and the send_* outputs are set to 0. Flush takes priority over push and pop.
- Entry contents are not cleared on reset or flush. Only the pointers are authoritative.
- Ordering: strict FIFO. An entry with multiple mask bits is issued once, as a multicast. The crossbar replicates it.

Test Plan:
- Reset then single push {to=8'h04, addr=15'h0123, word=64'hDEAD_BEEF} with hold=0 -> send_en=1 with identical fields exactly one cycle later, then 0. count goes 0->1->0.
- hold=1 and 4 pushes (DEPTH=4) -> count=4, in_ready=0. The 5th in_valid stalls. Release hold -> 4 consecutive send_en cycles with addrs in push order. in_ready rises the cycle after the first pop.
- Queue at count=2, then push and pop in the same cycle -> count stays 2. Sequence check over 16 random entries shows no loss and no reorder, including pointer wrap (more than 2×DEPTH entries).
- Push with in_to=0 -> handshake completes, count unchanged, no send_en, drop_err=1 and stays 1 until clr.
- Queue with 3 entries, flush pulsed for 1 cycle with in_valid=1 -> count=0, send_en=0, the pushed entry is absent. The next push is issued normally.
- clr asserted mid-stream while send_en=1 -> all outputs go to 0 immediately (asynchronously). After release, no stale entry is issued.

Source files
------------

// File: rtl/interconn_txq.sv
// Per-MVU outbound transmit queue: buffers write requests in a circular FIFO and
// issues them one per cycle to the crossbar source port through registered outputs.
module interconn_txq #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 64,
  parameter int unsigned BADDR = 15,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_to,
  input  logic [BADDR-1:0] in_addr,
  input  logic [W-1:0]     in_word,
  input  logic             hold,
  input  logic             flush,
  output logic [N-1:0]     send_to,
  output logic             send_en,
  output logic [BADDR-1:0] send_addr,
  output logic [W-1:0]     send_word,
  output logic [AW:0]      count,
  output logic             drop_err
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = N + BADDR + W;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          accept;
  logic          push;
  logic          zero_req;
  logic          pop;

  // Status flags derive from registered pointers only; no look-ahead on a same-cycle pop.
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    in_ready = !clr && !full && !flush;
    accept   = in_valid && in_ready;
    push     = accept && (in_to != '0);
    zero_req = accept && (in_to == '0);
    pop      = !empty && !hold && !flush;
    count    = wr_ptr - rd_ptr;
  end

  // Entry storage; pointers alone are authoritative, so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {in_to, in_addr, in_word};
    end
  end

  // Pointers, issue registers and sticky error. Flush overrides push and pop.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      send_en   <= 1'b0;
      send_to   <= '0;
      send_addr <= '0;
      send_word <= '0;
      drop_err  <= 1'b0;
    end else begin
      if (zero_req) begin
        drop_err <= 1'b1;
      end
      if (flush) begin
        rd_ptr    <= wr_ptr;
        send_en   <= 1'b0;
        send_to   <= '0;
        send_addr <= '0;
        send_word <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr                           <= rd_ptr + PW'(1);
          send_en                          <= 1'b1;
          {send_to, send_addr, send_word}  <= mem[rd_ptr[AW-1:0]];
        end else begin
          // Idle source drives zeros so the crossbar OR-reduction stays clean.
          send_en   <= 1'b0;
          send_to   <= '0;
          send_addr <= '0;
          send_word <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_interconn_txq.sv
// Directed self-checking bench for interconn_txq.
module tb_interconn_txq;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_to;
  logic [14:0] in_addr;
  logic [63:0] in_word;
  logic        hold;
  logic        flush;
  logic [7:0]  send_to;
  logic        send_en;
  logic [14:0] send_addr;
  logic [63:0] send_word;
  logic [2:0]  count;
  logic        drop_err;

  int checks = 0;
  int errors = 0;

  interconn_txq #(.N(8), .W(64), .BADDR(15), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_to(in_to), .in_addr(in_addr), .in_word(in_word), .hold(hold),
    .flush(flush), .send_to(send_to), .send_en(send_en), .send_addr(send_addr),
    .send_word(send_word), .count(count), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; in_valid = 1'b0; in_to = '0; in_addr = '0; in_word = '0;
    hold = 1'b0; flush = 1'b0;
    step(); step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL reset_send_en got %b want 0", send_en); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if ({send_to, send_addr, send_word} !== 87'd0) begin errors++; $display("FAIL reset_send_fields got %h want 0", {send_to, send_addr, send_word}); end
    checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got %b want 0", drop_err); end
    clr = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_to = 8'h04; in_addr = 15'h0123; in_word = 64'hDEAD_BEEF;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL single_early_en got %b want 0", send_en); end
    step();
    checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL single_en got %b want 1", send_en); end
    checks++; if ({send_to, send_addr, send_word} !== {8'h04, 15'h0123, 64'hDEAD_BEEF})
      begin errors++; $display("FAIL single_fields got %h want %h", {send_to, send_addr, send_word}, {8'h04, 15'h0123, 64'hDEAD_BEEF}); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", count); end
    step();
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL single_en_drop got %b want 0", send_en); end
    checks++; if (send_addr !== 15'h0) begin errors++; $display("FAIL single_addr_zero got %h want 0", send_addr); end
  endtask

  task automatic test_hold_full();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_to = 8'(1 << i); in_addr = 15'(16 + i); in_word = 64'(i);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
    in_addr = 15'h7FF; in_to = 8'hFF;
    step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_stall_count got %0d want 4", count); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL full_hold_en got %b want 0", send_en); end
    in_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (send_en !== 1'b1 || send_addr !== 15'(16 + i) || send_to !== 8'(1 << i))
        begin errors++; $display("FAIL full_drain%0d got en=%b addr=%h to=%h want en=1 addr=%h to=%h", i, send_en, send_addr, send_to, 15'(16 + i), 8'(1 << i)); end
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got %b want 1", in_ready); end
      end
    end
    step();
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL full_drained_en got %b want 0", send_en); end
  endtask

  task automatic test_back_to_back();
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_to = 8'h10; in_addr = 15'(15'h100 + i); in_word = 64'(100 + i);
      step();
    end
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_pre_count got %0d want 2", count); end
    hold = 1'b0; in_addr = 15'h102; in_word = 64'd102;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", count); end
    checks++; if (send_en !== 1'b1 || send_addr !== 15'h100) begin errors++; $display("FAIL b2b_pop0 got en=%b addr=%h want en=1 addr=100", send_en, send_addr); end
    step();
    checks++; if (send_en !== 1'b1 || send_addr !== 15'h101) begin errors++; $display("FAIL b2b_pop1 got en=%b addr=%h want en=1 addr=101", send_en, send_addr); end
    step();
    checks++; if (send_en !== 1'b1 || send_addr !== 15'h102 || send_word !== 64'd102) begin errors++; $display("FAIL b2b_pop2 got en=%b addr=%h want en=1 addr=102", send_en, send_addr); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_end_count got %0d want 0", count); end
    step();
  endtask

  task automatic test_stream();
    logic [86:0] q[$];
    logic [86:0] e;
    logic        rdy;
    logic        pp;
    int          pushed = 0;
    int          cyc = 0;
    e = '0;
    while ((pushed < 16 || q.size() > 0) && cyc < 300) begin
      in_valid = (pushed < 16) && ($urandom_range(0, 3) != 0);
      hold     = ($urandom_range(0, 3) == 0);
      in_to    = 8'($urandom_range(1, 255));
      in_addr  = 15'($urandom);
      in_word  = {$urandom, $urandom};
      #1;
      rdy = (q.size() < 4);
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL stream_ready cyc%0d got %b want %b", cyc, in_ready, rdy); end
      pp = (q.size() > 0) && !hold;
      if (pp) e = q.pop_front();
      if (in_valid && rdy) begin
        q.push_back({in_to, in_addr, in_word});
        pushed++;
      end
      step();
      checks++; if (send_en !== pp) begin errors++; $display("FAIL stream_en cyc%0d got %b want %b", cyc, send_en, pp); end
      if (pp) begin
        checks++; if ({send_to, send_addr, send_word} !== e) begin errors++; $display("FAIL stream_data cyc%0d got %h want %h", cyc, {send_to, send_addr, send_word}, e); end
      end
      checks++; if (count !== 3'(q.size())) begin errors++; $display("FAIL stream_count cyc%0d got %0d want %0d", cyc, count, q.size()); end
      cyc++;
    end
    in_valid = 1'b0; hold = 1'b0;
    checks++; if (cyc >= 300) begin errors++; $display("FAIL stream_timeout got %0d cycles want <300", cyc); end
    step();
  endtask

  task automatic test_zero_mask();
    in_valid = 1'b1; in_to = 8'h00; in_addr = 15'h0AAA; in_word = 64'h1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count got %0d want 0", count); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL zero_drop_err got %b want 1", drop_err); end
    step();
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL zero_no_send got %b want 0", send_en); end
    step(); step();
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL zero_sticky got %b want 1", drop_err); end
  endtask

  task automatic test_flush();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_to = 8'h02; in_addr = 15'(15'h200 + i); in_word = 64'(i);
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", count); end
    flush = 1'b1; in_addr = 15'h555;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; hold = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL flush_en got %b want 0", send_en); end
    step();
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL flush_no_stale got %b want 0", send_en); end
    in_valid = 1'b1; in_to = 8'h80; in_addr = 15'h321; in_word = 64'h77;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (send_en !== 1'b1 || send_addr !== 15'h321 || send_to !== 8'h80) begin errors++; $display("FAIL flush_next got en=%b addr=%h to=%h want en=1 addr=321 to=80", send_en, send_addr, send_to); end
    step();
  endtask

  task automatic test_clr_mid();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_to = 8'h01; in_addr = 15'(15'h400 + i); in_word = 64'hF0;
      step();
    end
    in_valid = 1'b0;
    checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL clr_pre_en got %b want 1", send_en); end
    checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL clr_pre_drop got %b want 1", drop_err); end
    #2 clr = 1'b1;
    #1;
    checks++; if (send_en !== 1'b0 || send_addr !== 15'h0 || send_to !== 8'h0 || send_word !== 64'h0)
      begin errors++; $display("FAIL clr_async got en=%b addr=%h want all 0", send_en, send_addr); end
    checks++; if (count !== 3'd0 || in_ready !== 1'b0 || drop_err !== 1'b0)
      begin errors++; $display("FAIL clr_async_state got count=%0d ready=%b drop=%b want 0 0 0", count, in_ready, drop_err); end
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL clr_stale%0d got %b want 0", i, send_en); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_full();
    test_back_to_back();
    test_stream();
    test_zero_mask();
    test_flush();
    test_clr_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
